uart_rx_data_sampler: RTL and testbench

- Front-end of the UART receive path. Synchronises the serial line and counts oversampling clock edges within each bit period.
- Takes a 3-sample majority vote around mid-bit and presents the resolved bit with a one-cycle new-bit strobe.
- Downstream consumers are the parity checker, the deserializer and the start/stop checks. The RX FSM controls this block through two enables and reads its edge and bit counters.

---
 rtl/uart_rx_data_sampler.sv | 132 +++++++++++++
 tb/tb_uart_rx_data_sampler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_data_sampler.sv
// UART receive front-end: two-flop line synchroniser, per-bit edge/bit
// counters and a three-sample majority vote taken around mid-bit.
// The RX FSM drives cnt_en / dat_samp_en and reads edge_cnt / bit_cnt.
module uart_rx_data_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  RX_IN,
    input  logic                  cnt_en,
    input  logic                  dat_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sampled_bit,
    output logic                  new_bit,
    output logic                  rx_sync
);

    // Only 8, 16 and 32 are meaningful ratios; everything else falls back to 8
    // so a bad Prescale can never produce a zero-length or odd bit period.
    function automatic logic [PRESCALE_W-1:0] legal_ratio(input logic [PRESCALE_W-1:0] p);
        logic [PRESCALE_W-1:0] r;
        if (p == PRESCALE_W'(8) || p == PRESCALE_W'(16) || p == PRESCALE_W'(32)) begin
            r = p;
        end else begin
            r = PRESCALE_W'(8);
        end
        return r;
    endfunction

    // Two-out-of-three vote; one corrupted sample cannot flip the bit.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic                  sync_ff1;
    logic                  sync_ff2;
    logic                  s0;
    logic                  s1;
    logic                  s2;
    logic [PRESCALE_W-1:0] ratio;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] pos_s0;
    logic [PRESCALE_W-1:0] pos_s1;
    logic [PRESCALE_W-1:0] pos_s2;
    logic [PRESCALE_W-1:0] pos_vote;
    logic                  sample_ok;
    logic                  vote_now;

    // Decode the effective ratio and the edge indices of the three samples
    // and of the vote; all are centred on the half-bit point.
    always_comb begin
        ratio     = legal_ratio(Prescale);
        half      = ratio >> 1;
        last_edge = ratio - PRESCALE_W'(1);
        pos_s0    = half - PRESCALE_W'(2);
        pos_s1    = half - PRESCALE_W'(1);
        pos_s2    = half;
        pos_vote  = half + PRESCALE_W'(1);
        sample_ok = cnt_en & dat_samp_en;
        vote_now  = sample_ok & (edge_cnt == pos_vote);
    end

    // Free-running two-flop synchroniser; idles high like the line itself.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_ff1 <= 1'b1;
            sync_ff2 <= 1'b1;
        end else begin
            sync_ff1 <= RX_IN;
            sync_ff2 <= sync_ff1;
        end
    end

    assign rx_sync = sync_ff2;

    // Edge counter wraps at the last edge of the bit and advances the bit
    // counter on the same clock. The >= compare also recovers if Prescale
    // shrinks while the counter is already beyond the new last edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt >= last_edge) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
    end

    // Capture the synchronised line at the three mid-bit edges. Values from
    // an aborted bit simply linger until the next bit overwrites them.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else if (sample_ok) begin
            if (edge_cnt == pos_s0) begin
                s0 <= rx_sync;
            end
            if (edge_cnt == pos_s1) begin
                s1 <= rx_sync;
            end
            if (edge_cnt == pos_s2) begin
                s2 <= rx_sync;
            end
        end
    end

    // Resolve the bit one edge after the last sample; new_bit is high for the
    // single cycle following the vote edge and sampled_bit holds otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sampled_bit <= 1'b1;
            new_bit     <= 1'b0;
        end else begin
            new_bit <= vote_now;
            if (vote_now) begin
                sampled_bit <= majority3(s0, s1, s2);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Directed bench for uart_rx_data_sampler: per-cycle line/enable tables,
// a small counter model and a queue of expected voted bits.
module tb_uart_rx_data_sampler;

    localparam int PW = 6;
    localparam int BW = 4;
    localparam int DEPTH = 256;

    logic          CLK = 1'b0;
    logic          RST;
    logic [PW-1:0] Prescale;
    logic          RX_IN;
    logic          cnt_en;
    logic          dat_samp_en;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          sampled_bit;
    logic          new_bit;
    logic          rx_sync;

    int checks = 0;
    int errors = 0;

    // desired rx_sync value, cnt_en and dat_samp_en per cycle of a segment
    logic line_v [DEPTH];
    logic cen_v  [DEPTH];
    logic dse_v  [DEPTH];
    logic exp_q  [$];
    logic exp_sb;
    int   probe_c;
    logic [31:0] probe_v;

    uart_rx_data_sampler #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Prescale    (Prescale),
        .RX_IN       (RX_IN),
        .cnt_en      (cnt_en),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .sampled_bit (sampled_bit),
        .new_bit     (new_bit),
        .rx_sync     (rx_sync)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < DEPTH; i++) begin
            line_v[i] = 1'b1;
            cen_v[i]  = 1'b0;
            dse_v[i]  = 1'b0;
        end
        exp_q.delete();
        probe_c = -1;
    endtask

    task automatic set_bit(input int b, input int p, input logic v, input logic de);
        for (int e = 0; e < p; e++) begin
            line_v[b*p+e] = v;
            cen_v[b*p+e]  = 1'b1;
            dse_v[b*p+e]  = de;
        end
    endtask

    // Drive n cycles of the tables (RX_IN leads rx_sync by two cycles) and
    // check counters, strobes and the held bit every cycle. p is the ratio
    // the block is expected to use.
    task automatic run_seg(input int n, input int p);
        int pe;
        int pb;
        int prev_e;
        logic v;
        pe = 0;
        pb = 0;
        prev_e = 0;
        for (int c = -2; c < n; c++) begin
            @(posedge CLK);
            #1;
            RX_IN       = line_v[c+2];
            cnt_en      = (c >= 0) ? cen_v[c] : 1'b0;
            dat_samp_en = (c >= 0) ? dse_v[c] : 1'b0;
            @(negedge CLK);
            if (c >= 0) begin
                check("edge_cnt", edge_cnt, pe);
                check("bit_cnt", bit_cnt, pb);
                if (c == probe_c) probe_v = bit_cnt;
                if (new_bit === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", new_bit, 0);
                    end else begin
                        v = exp_q.pop_front();
                        check("sampled_bit", sampled_bit, v);
                        check("strobe_edge", prev_e, p/2 + 1);
                        exp_sb = v;
                    end
                end else begin
                    check("sampled_hold", sampled_bit, exp_sb);
                end
                prev_e = edge_cnt;
                if (cen_v[c]) begin
                    if (pe == p - 1) begin
                        pe = 0;
                        pb = (pb + 1) % (1 << BW);
                    end else begin
                        pe++;
                    end
                end else begin
                    pe = 0;
                    pb = 0;
                end
            end
        end
        check("strobes_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] frame;
        RST = 1'b0;
        Prescale = PW'(8);
        RX_IN = 1'b1;
        cnt_en = 1'b0;
        dat_samp_en = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // reset mid-activity with the line low
        @(posedge CLK);
        #1;
        RX_IN = 1'b0;
        cnt_en = 1'b1;
        dat_samp_en = 1'b1;
        repeat (12) @(posedge CLK);
        @(negedge CLK);
        check("pre_reset_sampled", sampled_bit, 0);
        #1;
        RST = 1'b0;
        #1;
        check("rst_edge_cnt", edge_cnt, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_sampled_bit", sampled_bit, 1);
        check("rst_new_bit", new_bit, 0);
        check("rst_rx_sync", rx_sync, 1);
        @(negedge CLK);
        cnt_en = 1'b0;
        dat_samp_en = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("sync_lag1", rx_sync, 1);
        @(posedge CLK);
        #1;
        check("sync_lag2", rx_sync, 0);
        RX_IN = 1'b1;
        repeat (4) @(posedge CLK);
        exp_sb = 1'b1;

        // clean frame 0xA5, P=8: start, 8 data LSB first, stop
        clear_stim();
        Prescale = PW'(8);
        frame = 8'hA5;
        set_bit(0, 8, 1'b0, 1'b1);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            set_bit(i + 1, 8, frame[i], 1'b1);
            exp_q.push_back(frame[i]);
        end
        set_bit(9, 8, 1'b1, 1'b1);
        exp_q.push_back(1'b1);
        run_seg(84, 8);

        // glitch rejection, P=16 (samples at edges 6,7,8)
        clear_stim();
        Prescale = PW'(16);
        set_bit(0, 16, 1'b0, 1'b1);
        line_v[8] = 1'b1;
        exp_q.push_back(1'b0);
        set_bit(1, 16, 1'b1, 1'b1);
        line_v[16+7] = 1'b0;
        exp_q.push_back(1'b1);
        set_bit(2, 16, 1'b1, 1'b1);
        line_v[32+6] = 1'b0;
        line_v[32+7] = 1'b0;
        exp_q.push_back(1'b0);
        run_seg(52, 16);

        // counters without sampling for 3 bits, then cnt_en drops
        clear_stim();
        Prescale = PW'(8);
        for (int b = 0; b < 3; b++) set_bit(b, 8, 1'b1, 1'b0);
        probe_c = 24;
        probe_v = '0;
        run_seg(28, 8);
        check("bit_cnt_reaches_3", probe_v, 3);

        // P=32: a one bit then an all-zero bit
        clear_stim();
        Prescale = PW'(32);
        set_bit(0, 32, 1'b1, 1'b1);
        exp_q.push_back(1'b1);
        set_bit(1, 32, 1'b0, 1'b1);
        exp_q.push_back(1'b0);
        run_seg(68, 32);

        // illegal Prescale=12 behaves as 8
        clear_stim();
        Prescale = PW'(12);
        set_bit(0, 8, 1'b0, 1'b1);
        exp_q.push_back(1'b0);
        set_bit(1, 8, 1'b1, 1'b1);
        exp_q.push_back(1'b1);
        run_seg(20, 8);

        // abort: dat_samp_en drops at edge 4 of the first bit
        clear_stim();
        Prescale = PW'(8);
        set_bit(0, 8, 1'b0, 1'b1);
        for (int e = 4; e < 8; e++) dse_v[e] = 1'b0;
        set_bit(1, 8, 1'b1, 1'b1);
        exp_q.push_back(1'b1);
        run_seg(20, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
